// File: rtl/game_pkg.sv
// Shared types and constants for the game input path.
package game_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONFIRM_HI = 2'd1,
        HELD       = 2'd2,
        CONFIRM_LO = 2'd3
    } btn_state_t;

    // Bit positions of the board buttons on the conditioner bus.
    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_LAUNCH = 2;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, then a confirm-counter FSM that
// accepts a change only after DEBOUNCE_CYCLES+1 consecutive stable samples.
// level/press/lift are registered; press and lift are one-cycle strobes.
//
// Handshake: none. raw is free-running and asynchronous; outputs are plain
// registered levels/strobes with no back-pressure.
module button_debounce_ch
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic lift
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Bring the raw pin into the clk domain before anything looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_a <= raw;
            s      <= sync_a;
        end
    end

    // Debounce FSM: a change is accepted only after the counter reaches
    // CNT_LAST with the synchronised input still at the new value; any
    // return to the old value drops back without a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            lift  <= 1'b0;
        end else begin
            press <= 1'b0;
            lift  <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= CONFIRM_HI;
                        cnt   <= '0;
                    end
                end
                CONFIRM_HI: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= CONFIRM_LO;
                        cnt   <= '0;
                    end
                end
                CONFIRM_LO: begin
                    if (s) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        level <= 1'b0;
                        lift  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw board buttons (left, right, launch) for the game logic.
// Each channel is an independent button_debounce_ch; outputs are bit-packed
// using the game_pkg BTN_* positions.
module button_conditioner
    import game_pkg::*;
#(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    // One identical debounce channel per button bit.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[g]),
            .level(btn_level[g]),
            .press(btn_press[g]),
            .lift (btn_release[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a short debounce window.
module tb_button_conditioner;

    localparam int NB = 3;
    localparam int D  = 4;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the input seen by the debouncer is the raw pin two
    // edges late; a button flips when the last D+1 seen samples all differ
    // from its current accepted level.
    logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    logic [D:0]    m_hist [NB];
    logic [D:0]    m_win;
    logic          m_tgt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 <= '0;
            m_s2 <= '0;
            m_level <= '0;
            m_press <= '0;
            m_rel <= '0;
            for (int i = 0; i < NB; i++) m_hist[i] <= '0;
        end else begin
            m_s1 <= btn_raw;
            m_s2 <= m_s1;
            m_press <= '0;
            m_rel <= '0;
            for (int i = 0; i < NB; i++) begin
                m_win = {m_hist[i][D-1:0], m_s2[i]};
                m_tgt = ~m_level[i];
                m_hist[i] <= m_win;
                if (m_win == {(D+1){m_tgt}}) begin
                    m_level[i] <= m_tgt;
                    if (m_tgt) m_press[i] <= 1'b1;
                    else       m_rel[i] <= 1'b1;
                end
            end
        end
    end

    // scoreboard compare
    task automatic check(input string name, input logic [3*NB-1:0] exp);
        logic [3*NB-1:0] act;
        act = {btn_level, btn_press, btn_release};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got level/press/release %b/%b/%b, want %b/%b/%b",
                     name, act[3*NB-1:2*NB], act[2*NB-1:NB], act[NB-1:0],
                     exp[3*NB-1:2*NB], exp[2*NB-1:NB], exp[NB-1:0]);
        end
    endtask

    // driver: apply raw before the next edge, check just after it
    task automatic step_expect(input string name, input logic [NB-1:0] raw,
                               input logic [NB-1:0] lvl, input logic [NB-1:0] prs,
                               input logic [NB-1:0] rel);
        @(negedge clk);
        btn_raw = raw;
        @(posedge clk);
        #1;
        check(name, {lvl, prs, rel});
    endtask

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [NB-1:0] raw, input int n, input logic [NB-1:0] lvl,
                       input logic [NB-1:0] prs, input logic [NB-1:0] rel);
        vec_t v;
        v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    int hold [NB];

    initial begin
        rst = 1'b1;
        btn_raw = '0;
        #12;
        check("reset_state", '0);
        @(negedge clk);
        rst = 1'b0;

        // each row: raw before edge k, outputs after edge k
        // clean press on left: accepted at edge D+3
        add(3'b001, 6, 3'b000, 3'b000, 3'b000);
        add(3'b001, 1, 3'b001, 3'b001, 3'b000);
        add(3'b001, 4, 3'b001, 3'b000, 3'b000);
        // 2-cycle low glitch while held: no release
        add(3'b000, 2, 3'b001, 3'b000, 3'b000);
        add(3'b001, 10, 3'b001, 3'b000, 3'b000);
        // clean release on left
        add(3'b000, 6, 3'b001, 3'b000, 3'b000);
        add(3'b000, 1, 3'b000, 3'b000, 3'b001);
        add(3'b000, 3, 3'b000, 3'b000, 3'b000);
        // 3-cycle high glitch on right: nothing
        add(3'b010, 3, 3'b000, 3'b000, 3'b000);
        add(3'b000, 8, 3'b000, 3'b000, 3'b000);
        // bounce 1,0,1,1.. on right: press 7 edges after last rise
        add(3'b010, 1, 3'b000, 3'b000, 3'b000);
        add(3'b000, 1, 3'b000, 3'b000, 3'b000);
        add(3'b010, 6, 3'b000, 3'b000, 3'b000);
        add(3'b010, 1, 3'b010, 3'b010, 3'b000);
        add(3'b010, 2, 3'b010, 3'b000, 3'b000);
        add(3'b000, 6, 3'b010, 3'b000, 3'b000);
        add(3'b000, 1, 3'b000, 3'b000, 3'b010);
        add(3'b000, 2, 3'b000, 3'b000, 3'b000);
        // simultaneous press and release of all three
        add(3'b111, 6, 3'b000, 3'b000, 3'b000);
        add(3'b111, 1, 3'b111, 3'b111, 3'b000);
        add(3'b111, 2, 3'b111, 3'b000, 3'b000);
        add(3'b000, 6, 3'b111, 3'b000, 3'b000);
        add(3'b000, 1, 3'b000, 3'b000, 3'b111);
        add(3'b000, 2, 3'b000, 3'b000, 3'b000);

        for (int k = 0; k < vecs.size(); k++)
            step_expect($sformatf("vec%0d", k), vecs[k].raw, vecs[k].lvl, vecs[k].prs, vecs[k].rel);

        // reset mid-operation: launch held, left confirming high
        for (int k = 0; k < 6; k++) step_expect("launch_pre", 3'b100, 3'b000, 3'b000, 3'b000);
        step_expect("launch_press", 3'b100, 3'b100, 3'b100, 3'b000);
        for (int k = 0; k < 4; k++) step_expect("left_confirm", 3'b101, 3'b100, 3'b000, 3'b000);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", '0);
        @(posedge clk);
        #1;
        check("reset_hold", '0);
        @(negedge clk);
        btn_raw = 3'b100;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_e1", '0);
        for (int k = 2; k <= 6; k++) step_expect($sformatf("post_reset_e%0d", k), 3'b100, 3'b000, 3'b000, 3'b000);
        step_expect("post_reset_press", 3'b100, 3'b100, 3'b100, 3'b000);
        step_expect("post_reset_after", 3'b100, 3'b100, 3'b000, 3'b000);

        // randomized phase against the reference model
        @(negedge clk);
        rst = 1'b1;
        btn_raw = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 10);
                end
                hold[i]--;
            end
            if (c == 1500) begin
                #2;
                rst = 1'b1;
                #1;
                check("rand_reset", {m_level, m_press, m_rel});
                @(negedge clk);
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            check("rand", {m_level, m_press, m_rel});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
